// File: rtl/dmem_responder.sv
// miniRV data-memory responder: one outstanding load/store over valid/ready,
// with sub-word extract/extend on loads and read-modify-write merge on stores.
module dmem_responder #(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t              state, state_nxt;
    logic                we_q;
    logic [2:0]          op_q;
    logic [ADDR_W+1:0]   adr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rbuf;
    logic [31:0]         mem [DEPTH];
    logic [ADDR_W-1:0]   idx;
    logic [31:0]         mem_word;
    logic [31:0]         wr_word;
    logic                accept;
    logic                mis_in;

    // Address bits above the array range are deliberately ignored (wrap).
    logic unused_adr;
    assign unused_adr = &{1'b0, req_adr[31:ADDR_W+2]};

    // op[1:0]: 00 byte, 01 half, anything else is a full word.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lane);
        case (op[1:0])
            2'b00:   return 1'b0;
            2'b01:   return lane[0];
            default: return lane != 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [2:0] op,
                                            input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (op[1:0])
            2'b00:   return op[2] ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return op[2] ? {16'h0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wdata,
                                          input logic [2:0] op, input logic [1:0] lane);
        logic [31:0] w;
        w = word;
        case (op[1:0])
            2'b00:   w[{lane, 3'b000} +: 8] = wdata[7:0];
            2'b01:   if (lane[1]) w[31:16] = wdata[15:0]; else w[15:0] = wdata[15:0];
            default: w = wdata;
        endcase
        return w;
    endfunction

    assign accept   = req_valid && req_ready;
    assign mis_in   = is_misaligned(req_op, req_adr[1:0]);
    assign idx      = adr_q[ADDR_W+1:2];
    assign mem_word = mem[idx];
    assign wr_word  = merge(rbuf, wdata_q, op_q, adr_q[1:0]);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: combinational blocks assign a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) begin
                if (mis_in)                    state_nxt = RESP;
                else if (req_we && req_op[1])  state_nxt = WR;
                else                           state_nxt = RD;
            end
            RD:   state_nxt = we_q ? WR : RESP;
            WR:   state_nxt = RESP;
            RESP: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE) && rst_n;
        resp_valid = (state == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            op_q       <= 3'b000;
            adr_q      <= '0;
            wdata_q    <= 32'h0;
            rbuf       <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                we_q       <= req_we;
                op_q       <= req_op;
                adr_q      <= req_adr[ADDR_W+1:0];
                wdata_q    <= req_wdata;
                resp_err   <= mis_in;
                resp_rdata <= 32'h0;
            end
            if (state == RD) begin
                rbuf <= mem_word;
                if (!we_q) resp_rdata <= extract(mem_word, op_q, adr_q[1:0]);
            end
            if (state == RESP && resp_ready) begin
                resp_rdata <= 32'h0;
                resp_err   <= 1'b0;
            end
        end
    end

    // NOTE: the word array has no reset; a reset before WR exit simply leaves it untouched.
    always_ff @(posedge clk) begin
        if (state == WR) mem[idx] <= wr_word;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array
// reference model built from byte-lane arithmetic.
module tb_dmem_responder;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_adr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference memory: only words whose full contents are known are present.
    logic [31:0] mdl [int];

    dmem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_op     (req_op),
        .req_adr    (req_adr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Predict a transaction's outcome and update the reference memory.
    task automatic model(input logic we, input logic [2:0] op, input logic [31:0] adr,
                         input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                         output int lat, output logic rd_known);
        int          size;
        int          widx;
        int          sh;
        logic [31:0] m;
        logic [31:0] v;
        size = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        err  = (size == 2 && adr[0]) || (size == 4 && adr[1:0] != 2'b00);
        rd       = 32'h0;
        rd_known = 1'b1;
        lat      = 1;
        if (!err) begin
            widx = int'((adr >> 2) % DEPTH);
            sh   = (size == 4) ? 0 : int'(adr[1:0]) * 8;
            m    = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
            if (we) begin
                lat = (size == 4) ? 2 : 3;
                if (size == 4)
                    mdl[widx] = wdata;
                else if (mdl.exists(widx))
                    mdl[widx] = (mdl[widx] & ~(m << sh)) | ((wdata & m) << sh);
            end else begin
                lat = 2;
                if (mdl.exists(widx)) begin
                    v = (mdl[widx] >> sh) & m;
                    if (!op[2] && size < 4 && v[8*size-1]) v = v | ~m;
                    rd = v;
                end else begin
                    rd_known = 1'b0;
                end
            end
        end
    endtask

    task automatic xact(input logic we, input logic [2:0] op, input logic [31:0] adr,
                        input logic [31:0] wdata, input int hold, output logic [31:0] got_rd);
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat;
        logic        known;
        int          lat;
        int          n;
        model(we, op, adr, wdata, e_rd, e_err, e_lat, known);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_op    = op;
        req_adr   = adr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_op    = 3'($urandom);
        req_adr   = $urandom;
        req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got_rd = resp_rdata;
        check("latency", lat, e_lat);
        check("resp_err", resp_err, e_err);
        if (known) check("resp_rdata", resp_rdata, e_rd);
        check("ready_busy", req_ready, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", resp_valid, 1'b1);
            check("hold_err", resp_err, e_err);
            if (known) check("hold_rdata", resp_rdata, e_rd);
            check("hold_ready", req_ready, 1'b0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("clr_valid", resp_valid, 1'b0);
        check("clr_rdata", resp_rdata, 32'h0);
        check("clr_err", resp_err, 1'b0);
        check("ready_back", req_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_op     = 3'b000;
        req_adr    = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", resp_err, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", req_ready, 1'b1);

        // Word store/load.
        xact(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, r);
        xact(1'b0, 3'b010, 32'h100, 32'h0, 0, r);
        check("plan_word_load", r, 32'hDEAD_BEEF);

        // Byte merge and extract.
        xact(1'b1, 3'b010, 32'h200, 32'h1122_3344, 0, r);
        xact(1'b1, 3'b000, 32'h202, 32'h0000_00AA, 0, r);
        xact(1'b0, 3'b010, 32'h200, 32'h0, 0, r);
        check("plan_byte_merge", r, 32'h11AA_3344);
        xact(1'b0, 3'b000, 32'h202, 32'h0, 0, r);
        check("plan_byte_signed", r, 32'hFFFF_FFAA);
        xact(1'b0, 3'b100, 32'h202, 32'h0, 0, r);
        check("plan_byte_unsigned", r, 32'h0000_00AA);

        // Half merge and extract.
        xact(1'b1, 3'b010, 32'h204, 32'h0, 0, r);
        xact(1'b1, 3'b001, 32'h206, 32'hFFFF_8001, 0, r);
        xact(1'b0, 3'b010, 32'h204, 32'h0, 0, r);
        check("plan_half_merge", r, 32'h8001_0000);
        xact(1'b0, 3'b001, 32'h206, 32'h0, 0, r);
        check("plan_half_signed", r, 32'hFFFF_8001);
        xact(1'b0, 3'b101, 32'h204, 32'h0, 0, r);
        check("plan_half_unsigned", r, 32'h0000_0000);

        // Misaligned accesses leave memory untouched.
        xact(1'b1, 3'b010, 32'h101, 32'h1234_5678, 0, r);
        xact(1'b0, 3'b001, 32'h103, 32'h0, 0, r);
        xact(1'b0, 3'b010, 32'h100, 32'h0, 0, r);
        check("plan_misaligned_intact", r, 32'hDEAD_BEEF);

        // Backpressure and address wrap into word 0.
        xact(1'b0, 3'b010, 32'h100, 32'h0, 5, r);
        xact(1'b1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 5, r);
        xact(1'b0, 3'b010, 32'h0, 32'h0, 0, r);
        check("plan_wrap", r, 32'hCAFE_F00D);

        // Reset during the RD cycle of a byte store aborts without a write.
        xact(1'b1, 3'b010, 32'h300, 32'h1122_3344, 0, r);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_op    = 3'b000;
        req_adr   = 32'h301;
        req_wdata = 32'h0000_0055;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_req_ready", req_ready, 1'b0);
        check("abort_resp_valid", resp_valid, 1'b0);
        check("abort_resp_rdata", resp_rdata, 32'h0);
        check("abort_resp_err", resp_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_ready_back", req_ready, 1'b1);
        xact(1'b0, 3'b010, 32'h300, 32'h0, 0, r);
        check("abort_word_intact", r, 32'h1122_3344);

        // Randomized traffic over a small window of words with random upper address bits.
        for (int w = 0; w < 16; w++)
            xact(1'b1, 3'b010, ($urandom & 32'hFFFF_C000) | 32'(w << 2), $urandom, 0, r);
        for (int t = 0; t < 200; t++) begin
            a = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 15) << 2)
                | 32'($urandom_range(0, 3));
            xact(1'($urandom), 3'($urandom), a, $urandom, $urandom_range(0, 2), r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
